// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants and the entry record layout.
// Default widths match the core's 64-bit datapath and 32-entry register file.
// No logic here.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_DATA_W = 64;
  localparam int ROB_REG_W  = 5;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [ROB_DATA_W-1:0] pc;
    logic [ROB_REG_W-1:0]  rd;
    logic [ROB_DATA_W-1:0] value;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order-retire circular ROB with multi-channel CDB capture and operand lookup.
// Latency: alloc_tag/commit/lookup outputs are combinational from state; CDB results reach commit one cycle later.
// Backpressure: alloc_ready drops at count==DEPTH; head is held until commit_ready.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter  int DEPTH      = ROB_DEPTH,
  parameter  int DATA_W     = ROB_DATA_W,
  parameter  int REG_W      = ROB_REG_W,
  parameter  int NUM_CDB    = 2,
  parameter  int NUM_LOOKUP = 2,
  localparam int TAG_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [DATA_W-1:0]            alloc_pc,
  input  logic [REG_W-1:0]             alloc_rd,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]    cdb_value,
  input  logic [NUM_LOOKUP*TAG_W-1:0]  lookup_tag,
  output logic [NUM_LOOKUP-1:0]        lookup_ready,
  output logic [NUM_LOOKUP*DATA_W-1:0] lookup_value,
  output logic                         commit_valid,
  input  logic                         commit_ready,
  output logic [DATA_W-1:0]            commit_pc,
  output logic [REG_W-1:0]             commit_rd,
  output logic [DATA_W-1:0]            commit_value,
  output logic [TAG_W-1:0]             commit_tag,
  input  logic                         flush,
  output logic [CNT_W-1:0]             count
);

  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
  logic [DATA_W-1:0] pc_q    [DEPTH];
  logic [DATA_W-1:0] pc_d    [DEPTH];
  logic [REG_W-1:0]  rd_q    [DEPTH];
  logic [REG_W-1:0]  rd_d    [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [DATA_W-1:0] value_d [DEPTH];
  logic              full, empty, alloc_fire, commit_fire;

  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign alloc_ready  = !full;
  assign alloc_tag    = tail_q;
  assign alloc_fire   = alloc_valid && !full && !flush;
  // Stale head bits are masked by empty so a drained buffer never retires.
  assign commit_valid = !empty && valid_q[head_q] && done_q[head_q];
  assign commit_fire  = commit_valid && commit_ready && !flush;
  assign commit_pc    = pc_q[head_q];
  assign commit_rd    = rd_q[head_q];
  assign commit_value = value_q[head_q];
  assign commit_tag   = head_q;
  assign count        = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    value_d = value_q;

    // Walk channels high to low so the lowest-indexed channel lands last and wins.
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cdb_valid[c] && valid_q[cdb_tag[c*TAG_W +: TAG_W]]) begin
        value_d[cdb_tag[c*TAG_W +: TAG_W]] = cdb_value[c*DATA_W +: DATA_W];
        done_d[cdb_tag[c*TAG_W +: TAG_W]]  = 1'b1;
      end
    end

    if (commit_fire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + TAG_W'(1);
    end

    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      pc_d[tail_q]    = alloc_pc;
      rd_d[tail_q]    = alloc_rd;
      tail_d          = tail_q + TAG_W'(1);
    end

    if (alloc_fire && !commit_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (commit_fire && !alloc_fire) begin
      count_d = count_q - CNT_W'(1);
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      done_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payloads are qualified by valid/done, so they carry no reset.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    rd_q    <= rd_d;
    value_q <= value_d;
  end

  always_comb begin
    lookup_ready = '0;
    lookup_value = '0;
    for (int i = 0; i < NUM_LOOKUP; i++) begin
      lookup_ready[i] = valid_q[lookup_tag[i*TAG_W +: TAG_W]] && done_q[lookup_tag[i*TAG_W +: TAG_W]];
      lookup_value[i*DATA_W +: DATA_W] = value_q[lookup_tag[i*TAG_W +: TAG_W]];
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with an in-order commit scoreboard.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int D = ROB_DEPTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          alloc_valid;
  logic          alloc_ready;
  logic [63:0]   alloc_pc;
  logic [4:0]    alloc_rd;
  logic [3:0]    alloc_tag;
  logic [1:0]    cdb_valid;
  logic [7:0]    cdb_tag;
  logic [127:0]  cdb_value;
  logic [7:0]    lookup_tag;
  logic [1:0]    lookup_ready;
  logic [127:0]  lookup_value;
  logic          commit_valid;
  logic          commit_ready;
  logic [63:0]   commit_pc;
  logic [4:0]    commit_rd;
  logic [63:0]   commit_value;
  logic [3:0]    commit_tag;
  logic          flush;
  logic [4:0]    count;

  int n_cmp = 0;
  int n_err = 0;

  rob_entry_t m_ent [D];
  int m_head, m_tail, m_cnt;
  int sb [$];
  int last_tag = 0;
  int max_cnt  = 0;
  int prev_tag = 0;
  int saw_wrap = 0;
  int ft;

  reorder_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_pc     (alloc_pc),
    .alloc_rd     (alloc_rd),
    .alloc_tag    (alloc_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .lookup_tag   (lookup_tag),
    .lookup_ready (lookup_ready),
    .lookup_value (lookup_value),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_pc    (commit_pc),
    .commit_rd    (commit_rd),
    .commit_value (commit_value),
    .commit_tag   (commit_tag),
    .flush        (flush),
    .count        (count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < D; i++) m_ent[i] = '0;
    m_head = 0;
    m_tail = 0;
    m_cnt  = 0;
    sb.delete();
  endtask

  task automatic idle_in();
    alloc_valid  = 1'b0;
    alloc_pc     = '0;
    alloc_rd     = '0;
    cdb_valid    = '0;
    cdb_tag      = '0;
    cdb_value    = '0;
    commit_ready = 1'b0;
    flush        = 1'b0;
  endtask

  // One clock: drive, check pre-edge outputs against the model, clock, update the model.
  task automatic cyc(input logic av, input logic [63:0] pc, input logic [4:0] rd,
                     input logic [1:0] cv, input logic [3:0] t0, input logic [63:0] v0,
                     input logic [3:0] t1, input logic [63:0] v1,
                     input logic cr, input logic fl);
    logic exp_cv, fa, fc;
    int   t;
    alloc_valid  = av;
    alloc_pc     = pc;
    alloc_rd     = rd;
    cdb_valid    = cv;
    cdb_tag      = {t1, t0};
    cdb_value    = {v1, v0};
    commit_ready = cr;
    flush        = fl;
    #1;
    exp_cv = (m_cnt > 0) && m_ent[m_head].valid && m_ent[m_head].done;
    chk("alloc_ready", alloc_ready, m_cnt < D);
    chk("alloc_tag", alloc_tag, 64'(m_tail));
    chk("commit_valid", commit_valid, exp_cv);
    chk("count", count, 64'(m_cnt));
    if (int'(count) > max_cnt) max_cnt = int'(count);
    fa = av && (m_cnt < D) && !fl;
    fc = exp_cv && cr && !fl;
    if (fc) begin
      t = sb.pop_front();
      chk("commit_tag", commit_tag, 64'(t));
      chk("commit_pc", commit_pc, m_ent[t].pc);
      chk("commit_rd", commit_rd, 64'(m_ent[t].rd));
      chk("commit_value", commit_value, m_ent[t].value);
    end
    if (fa) begin
      if (prev_tag == 15 && alloc_tag == 4'd0) saw_wrap = 1;
      prev_tag = int'(alloc_tag);
      last_tag = m_tail;
    end
    @(posedge clk);
    #1;
    if (fl) begin
      mreset();
    end else begin
      for (int c = 1; c >= 0; c--) begin
        int tt;
        tt = (c == 1) ? int'(t1) : int'(t0);
        if (cv[c] && m_ent[tt].valid) begin
          m_ent[tt].value = (c == 1) ? v1 : v0;
          m_ent[tt].done  = 1'b1;
        end
      end
      if (fc) begin
        m_ent[m_head].valid = 1'b0;
        m_ent[m_head].done  = 1'b0;
        m_head = (m_head + 1) % D;
      end
      if (fa) begin
        m_ent[m_tail].valid = 1'b1;
        m_ent[m_tail].done  = 1'b0;
        m_ent[m_tail].pc    = pc;
        m_ent[m_tail].rd    = rd;
        sb.push_back(m_tail);
        m_tail = (m_tail + 1) % D;
      end
      m_cnt = m_cnt + int'(fa) - int'(fc);
    end
    idle_in();
  endtask

  task automatic alloc1(input logic [63:0] pc, input logic [4:0] rd);
    cyc(1'b1, pc, rd, 2'b00, 4'd0, 64'd0, 4'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic cdb2(input logic [1:0] cv, input logic [3:0] t0, input logic [63:0] v0,
                      input logic [3:0] t1, input logic [63:0] v1);
    cyc(1'b0, 64'd0, 5'd0, cv, t0, v0, t1, v1, 1'b0, 1'b0);
  endtask

  task automatic commit1();
    cyc(1'b0, 64'd0, 5'd0, 2'b00, 4'd0, 64'd0, 4'd0, 64'd0, 1'b1, 1'b0);
  endtask

  task automatic drain();
    int n, h;
    n = m_cnt;
    h = m_head;
    for (int k = 0; k < n; k += 2)
      cdb2((k + 1 < n) ? 2'b11 : 2'b01, 4'((h + k) % D), 64'(32'hD000 + k),
           4'((h + k + 1) % D), 64'(32'hD001 + k));
    for (int g = 0; g < 2 * D && m_cnt > 0; g++) commit1();
    chk("drain_count", count, 64'd0);
  endtask

  initial begin
    reset      = 1'b0;
    lookup_tag = {4'd1, 4'd0};
    idle_in();
    mreset();
    #12;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_lookup_ready", lookup_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Three allocations in program order.
    alloc1(64'h100, 5'd1);
    alloc1(64'h104, 5'd2);
    alloc1(64'h108, 5'd3);
    chk("cnt3", count, 3);
    chk("cv_after_alloc", commit_valid, 0);

    // Out-of-order completion, in-order retire.
    cdb2(2'b01, 4'd1, 64'hAA, 4'd0, 64'd0);
    lookup_tag = {4'd0, 4'd1};
    #1;
    chk("lk_t1_ready", lookup_ready[0], 1);
    chk("lk_t1_value", lookup_value[63:0], 64'hAA);
    chk("lk_t0_ready", lookup_ready[1], 0);
    chk("cv_head_not_done", commit_valid, 0);
    cdb2(2'b10, 4'd0, 64'd0, 4'd0, 64'h55);
    chk("c0_valid", commit_valid, 1);
    chk("c0_tag", commit_tag, 0);
    chk("c0_value", commit_value, 64'h55);
    chk("c0_pc", commit_pc, 64'h100);
    commit1();
    chk("c1_tag", commit_tag, 1);
    chk("c1_value", commit_value, 64'hAA);
    chk("c1_pc", commit_pc, 64'h104);
    commit1();
    chk("cv_t2_pending", commit_valid, 0);

    // Same-tag CDB collision, then a write to a freed tag.
    alloc1(64'h10C, 5'd4);
    cdb2(2'b11, 4'd3, 64'h11, 4'd3, 64'h22);
    lookup_tag = {4'd0, 4'd3};
    #1;
    chk("collide_ready", lookup_ready[0], 1);
    chk("collide_value", lookup_value[63:0], 64'h11);
    cdb2(2'b01, 4'd0, 64'h99, 4'd0, 64'd0);
    chk("freed_lk_ready", lookup_ready[1], 0);
    chk("freed_count", count, 2);
    cdb2(2'b01, 4'd2, 64'h2222, 4'd0, 64'd0);
    commit1();
    chk("c3_value", commit_value, 64'h11);
    commit1();
    chk("empty_count", count, 0);

    // Fill to DEPTH; a full cycle with alloc+commit only retires.
    for (int i = 0; i < D; i++) alloc1(64'(32'h200 + 4 * i), 5'(i));
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 16);
    cdb2(2'b01, 4'(m_head), 64'hF00, 4'd0, 64'd0);
    cyc(1'b1, 64'hDEAD, 5'd9, 2'b00, 4'd0, 64'd0, 4'd0, 64'd0, 1'b1, 1'b0);
    chk("full_commit_count", count, 15);
    chk("full_tail_held", alloc_tag, 4);
    alloc1(64'h300, 5'd7);
    chk("refill_count", count, 16);
    drain();

    // Streaming alloc/complete/commit across several pointer wraps.
    saw_wrap = 0;
    max_cnt  = 0;
    for (int i = 0; i < 40; i++)
      cyc(1'b1, 64'(32'h1000 + 4 * i), 5'((i % 31) + 1),
          (i > 0) ? 2'b01 : 2'b00, 4'(last_tag), 64'(32'hC000 + i),
          4'd0, 64'd0, 1'b1, 1'b0);
    drain();
    chk("tag_wrap_seen", saw_wrap, 1);
    chk("max_count_le_depth", max_cnt <= D, 1);

    // Flush overrides a simultaneous alloc and CDB.
    for (int i = 0; i < 5; i++) alloc1(64'(32'h400 + 4 * i), 5'(i + 1));
    ft = (m_head + 1) % D;
    cdb2(2'b01, 4'(m_head), 64'h123, 4'd0, 64'd0);
    cyc(1'b1, 64'h500, 5'd5, 2'b01, 4'(ft), 64'h456, 4'd0, 64'd0, 1'b1, 1'b1);
    lookup_tag = {4'(ft), 4'(ft)};
    #1;
    chk("flush_count", count, 0);
    chk("flush_alloc_tag", alloc_tag, 0);
    chk("flush_commit_valid", commit_valid, 0);
    chk("flush_lookup_ready", lookup_ready, 0);

    // Asynchronous reset mid-cycle.
    alloc1(64'h600, 5'd1);
    alloc1(64'h604, 5'd2);
    cdb2(2'b01, 4'd0, 64'h77, 4'd0, 64'd0);
    lookup_tag = {4'd0, 4'd0};
    #1;
    chk("pre_arst_cv", commit_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_alloc_tag", alloc_tag, 0);
    chk("arst_alloc_ready", alloc_ready, 1);
    chk("arst_commit_valid", commit_valid, 0);
    chk("arst_lookup_ready", lookup_ready, 0);
    mreset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    alloc1(64'h700, 5'd3);
    chk("post_arst_count", count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
